// File: rtl/sys_bus_bridge.sv
// CPU data-port bridge: decodes one registered request to data memory, a
// fixed-stride peripheral window or the interrupt-controller register pair.
module sys_bus_bridge #(
    parameter int unsigned NUM_DEV    = 4,
    parameter logic [31:0] DEV_BASE   = 32'h7f00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter logic [31:0] DEV_SPAN   = 32'd12,
    parameter logic [31:0] INT_BASE   = 32'h7f80,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    input  logic [3:0]              cpu_byteen,
    output logic                    cpu_ack,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_err,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_byteen,
    input  logic [31:0]             mem_rdata,
    output logic [31:0]             dev_addr,
    output logic [31:0]             dev_wdata,
    output logic [NUM_DEV-1:0]      dev_we,
    output logic [NUM_DEV-1:0]      dev_re,
    input  logic [32*NUM_DEV-1:0]   dev_rdata,
    input  logic [NUM_DEV-1:0]      dev_ready,
    input  logic [NUM_DEV-1:0]      dev_irq,
    output logic                    int_req
);

    localparam int unsigned CW          = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TO_VAL    = CW'(TIMEOUT);
    localparam logic [31:0] DEV_END_OFS = 32'(NUM_DEV) * DEV_STRIDE;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
    typedef enum logic [1:0] {T_MEM, T_DEV, T_INTC, T_UNMAP} tgt_t;

    state_t               state, state_n;
    tgt_t                 dec_tgt, lat_tgt;
    logic [NUM_DEV-1:0]   dec_oh, lat_oh;
    logic [31:0]          dev_ofs;
    logic [31:0]          lat_addr, lat_wdata;
    logic [3:0]           lat_be;
    logic [CW-1:0]        cnt, cnt_n;
    logic [31:0]          resp_data, resp_data_n;
    logic                 resp_err, resp_err_n;
    logic [NUM_DEV-1:0]   mask, mask_n, pend, pend_clr;
    logic [31:0]          sel_rdata;
    logic                 sel_ready;
    logic                 is_write, full_word;

    // Address decode on the incoming request; result is latched with it.
    always_comb begin
        dev_ofs = cpu_addr - DEV_BASE;
        dec_oh  = '0;
        dec_tgt = T_UNMAP;
        if (cpu_addr < DEV_BASE) begin
            dec_tgt = T_MEM;
        end else if (dev_ofs < DEV_END_OFS) begin
            for (int unsigned i = 0; i < NUM_DEV; i++) begin
                if (dev_ofs >= 32'(i) * DEV_STRIDE &&
                    dev_ofs <  32'(i) * DEV_STRIDE + DEV_SPAN)
                    dec_oh[i] = 1'b1;
            end
            if (dec_oh != '0)
                dec_tgt = T_DEV;
        end else if (cpu_addr == INT_BASE || cpu_addr == INT_BASE + 32'd4) begin
            dec_tgt = T_INTC;
        end
    end

    always_comb begin
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (lat_oh[i])
                sel_rdata = sel_rdata | dev_rdata[32*i +: 32];
        end
        sel_ready = |(dev_ready & lat_oh);
    end

    assign is_write  = (lat_be != 4'b0000);
    assign full_word = (lat_be == 4'b1111);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        resp_data_n = resp_data;
        resp_err_n  = resp_err;
        mask_n      = mask;
        pend_clr    = '0;
        dev_we      = '0;
        dev_re      = '0;
        mem_byteen  = '0;
        case (state)
            S_IDLE: begin
                if (cpu_req)
                    state_n = S_ACCESS;
            end
            S_ACCESS: begin
                case (lat_tgt)
                    T_MEM: begin
                        mem_byteen  = lat_be;
                        resp_data_n = mem_rdata;
                        resp_err_n  = 1'b0;
                        state_n     = S_RESP;
                    end
                    T_DEV: begin
                        if (is_write && !full_word) begin
                            resp_data_n = '0;
                            resp_err_n  = 1'b1;
                            state_n     = S_RESP;
                        end else begin
                            if (is_write)
                                dev_we = lat_oh;
                            else
                                dev_re = lat_oh;
                            // Timeout is judged on the count reached so far,
                            // so TIMEOUT+1 strobe cycles precede the error.
                            if (sel_ready) begin
                                resp_data_n = is_write ? '0 : sel_rdata;
                                resp_err_n  = 1'b0;
                                cnt_n       = '0;
                                state_n     = S_RESP;
                            end else if (cnt == TO_VAL) begin
                                resp_data_n = '0;
                                resp_err_n  = 1'b1;
                                cnt_n       = '0;
                                state_n     = S_RESP;
                            end else begin
                                cnt_n = cnt + 1'b1;
                            end
                        end
                    end
                    T_INTC: begin
                        resp_data_n = '0;
                        resp_err_n  = 1'b0;
                        if (is_write && !full_word) begin
                            resp_err_n = 1'b1;
                        end else if (is_write) begin
                            if (lat_addr == INT_BASE)
                                mask_n = lat_wdata[NUM_DEV-1:0];
                            else
                                pend_clr = lat_wdata[NUM_DEV-1:0];
                        end else begin
                            resp_data_n = (lat_addr == INT_BASE) ? 32'(mask) : 32'(pend);
                        end
                        state_n = S_RESP;
                    end
                    default: begin
                        resp_data_n = '0;
                        resp_err_n  = 1'b1;
                        state_n     = S_RESP;
                    end
                endcase
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            lat_tgt   <= T_MEM;
            lat_oh    <= '0;
            cnt       <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
            mask      <= '0;
            pend      <= '0;
            int_req   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            resp_data <= resp_data_n;
            resp_err  <= resp_err_n;
            mask      <= mask_n;
            // A new interrupt overrides a clear of the same bit.
            pend      <= (pend & ~pend_clr) | dev_irq;
            int_req   <= |(pend & mask);
            if (state == S_IDLE && cpu_req) begin
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
                lat_be    <= cpu_byteen;
                lat_tgt   <= dec_tgt;
                lat_oh    <= dec_oh;
            end
        end
    end

    assign cpu_ack   = (state == S_RESP);
    assign cpu_rdata = resp_data;
    assign cpu_err   = resp_err;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign dev_addr  = lat_addr;
    assign dev_wdata = lat_wdata;

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Directed bench for sys_bus_bridge: vector table of single transactions plus
// hand sequences for interrupt pending/mask and reset during an access.
module tb_sys_bus_bridge;

    localparam int unsigned NUM_DEV = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cpu_req;
    logic [31:0]           cpu_addr, cpu_wdata;
    logic [3:0]            cpu_byteen;
    logic                  cpu_ack, cpu_err;
    logic [31:0]           cpu_rdata;
    logic [31:0]           mem_addr, mem_wdata, mem_rdata;
    logic [3:0]            mem_byteen;
    logic [31:0]           dev_addr, dev_wdata;
    logic [NUM_DEV-1:0]    dev_we, dev_re, dev_ready, dev_irq;
    logic [32*NUM_DEV-1:0] dev_rdata;
    logic                  int_req;

    int n_cmp = 0;
    int n_bad = 0;

    sys_bus_bridge #(
        .NUM_DEV(NUM_DEV),
        .DEV_BASE(32'h7f00),
        .DEV_STRIDE(32'h10),
        .DEV_SPAN(32'd12),
        .INT_BASE(32'h7f80),
        .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_byteen(cpu_byteen), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byteen(mem_byteen), .mem_rdata(mem_rdata), .dev_addr(dev_addr),
        .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_re(dev_re),
        .dev_rdata(dev_rdata), .dev_ready(dev_ready), .dev_irq(dev_irq),
        .int_req(int_req)
    );

    always #5 clk = ~clk;

    // Data memory model: combinational read, byte-enabled write.
    logic [31:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_byteen[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stall;      // cycles before dev_ready rises; 255 = never
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_we;
        int          exp_we_cyc;
        logic [3:0]  exp_re;
        int          exp_re_cyc;
        logic [3:0]  exp_mem_be;
        int          exp_mem_cyc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int k, lat, we_c, re_c, mb_c;
        logic ack_seen, er;
        logic [31:0] rd, da;
        logic [3:0] we_or, re_or, mb_or;
        @(negedge clk);
        cpu_req    = 1'b1;
        cpu_addr   = v.addr;
        cpu_wdata  = v.wdata;
        cpu_byteen = v.be;
        dev_ready  = (v.stall == 0) ? '1 : '0;
        @(posedge clk); #1;
        cpu_req  = 1'b0;
        cpu_addr = 32'hffff_fffc;
        k = 0; lat = 0; we_c = 0; re_c = 0; mb_c = 0;
        ack_seen = 1'b0; er = 1'b0; rd = '0; da = '0;
        we_or = '0; re_or = '0; mb_or = '0;
        while (!ack_seen && k < 40) begin
            if (k >= v.stall) dev_ready = '1;
            if (dev_we != 0) begin we_c++; we_or |= dev_we; end
            if (dev_re != 0) begin re_c++; re_or |= dev_re; end
            if (mem_byteen != 0) begin mb_c++; mb_or |= mem_byteen; end
            if (cpu_ack) begin
                ack_seen = 1'b1; lat = k + 1; rd = cpu_rdata; er = cpu_err; da = dev_addr;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        dev_ready = '1;
        check({nm, "_ack"}, 32'(ack_seen), 32'd1);
        check({nm, "_lat"}, lat, v.exp_lat);
        check({nm, "_rdata"}, rd, v.exp_rdata);
        check({nm, "_err"}, 32'(er), 32'(v.exp_err));
        check({nm, "_devaddr"}, da, v.addr);
        check({nm, "_we"}, {we_c[27:0], we_or}, {v.exp_we_cyc[27:0], v.exp_we});
        check({nm, "_re"}, {re_c[27:0], re_or}, {v.exp_re_cyc[27:0], v.exp_re});
        check({nm, "_membe"}, {mb_c[27:0], mb_or}, {v.exp_mem_cyc[27:0], v.exp_mem_be});
        @(posedge clk); #1;
        check({nm, "_ackdrop"}, 32'(cpu_ack), 32'd0);
    endtask

    task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] er_d, input logic er, input string nm);
        vec_t t;
        t = '{a, d, be, 0, er_d, er, 2, 4'h0, 0, 4'h0, 0, 4'h0, 0};
        run_vec(t, nm);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        //          addr         wdata          be    stl  rdata          err lat we   wc  re   rc  mbe  mc
        vecs[0]  = '{32'h0040, 32'h12345678, 4'hF, 0,   32'h0,         0, 2,  4'h0, 0, 4'h0, 0, 4'hF, 1};
        vecs[1]  = '{32'h0040, 32'h0,        4'h0, 0,   32'h12345678,  0, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[2]  = '{32'h0044, 32'h000000AB, 4'h1, 0,   32'h0,         0, 2,  4'h0, 0, 4'h0, 0, 4'h1, 1};
        vecs[3]  = '{32'h0044, 32'h0,        4'h0, 0,   32'h000000AB,  0, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[4]  = '{32'h7f14, 32'h0,        4'h0, 3,   32'h000000A5,  0, 5,  4'h0, 0, 4'h2, 4, 4'h0, 0};
        vecs[5]  = '{32'h7f20, 32'hDEADBEEF, 4'hF, 255, 32'h0,         1, 17, 4'h4, 16, 4'h0, 0, 4'h0, 0};
        vecs[6]  = '{32'h7f0c, 32'h0,        4'h0, 0,   32'h0,         1, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[7]  = '{32'h7f50, 32'h0,        4'h0, 0,   32'h0,         1, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[8]  = '{32'h7f00, 32'h55555555, 4'h3, 0,   32'h0,         1, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[9]  = '{32'h7f3b, 32'h0,        4'h0, 0,   32'hD0000003,  0, 2,  4'h0, 0, 4'h8, 1, 4'h0, 0};
        vecs[10] = '{32'h7f04, 32'h11112222, 4'hF, 1,   32'h0,         0, 3,  4'h1, 2, 4'h0, 0, 4'h0, 0};
        vecs[11] = '{32'h7f84, 32'h0,        4'h0, 0,   32'h0,         0, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[12] = '{32'h7f7c, 32'h0,        4'h0, 0,   32'h0,         1, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[13] = '{32'h7f88, 32'h0,        4'h0, 0,   32'h0,         1, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[14] = '{32'h7f80, 32'hFFFFFFF2, 4'hF, 0,   32'h0,         0, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[15] = '{32'h7f80, 32'h0,        4'h0, 0,   32'h2,         0, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[16] = '{32'h7f80, 32'h0,        4'h8, 0,   32'h0,         1, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[17] = '{32'h7f80, 32'h0,        4'h0, 0,   32'h2,         0, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[18] = '{32'h7f40, 32'h0,        4'h0, 0,   32'h0,         1, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};
        vecs[19] = '{32'h7efc, 32'h0,        4'h0, 0,   32'h0,         0, 2,  4'h0, 0, 4'h0, 0, 4'h0, 0};

        reset = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0;
        dev_ready = '1; dev_irq = '0;
        dev_rdata = {32'hD0000003, 32'hD0000002, 32'h000000A5, 32'hD0000000};
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(cpu_ack), 0);
        check("rst_err", 32'(cpu_err), 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_intreq", 32'(int_req), 0);
        check("rst_strobes", {dev_we, dev_re, mem_byteen}, 0);
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // MASK = 2 from the table; pulse irq[1]
        @(negedge clk); dev_irq = 4'h2;
        @(posedge clk); #1;
        check("irq_intreq_lag", 32'(int_req), 0);
        @(negedge clk); dev_irq = 4'h0;
        @(posedge clk); #1;
        check("irq_intreq_set", 32'(int_req), 1);
        acc(32'h7f84, 32'h0, 4'h0, 32'h2, 1'b0, "pend_rd1");
        // W1C while the same line is still asserted
        dev_irq = 4'h2;
        acc(32'h7f84, 32'h2, 4'hF, 32'h0, 1'b0, "pend_w1c_race");
        dev_irq = 4'h0;
        acc(32'h7f84, 32'h0, 4'h0, 32'h2, 1'b0, "pend_rd2");
        check("irq_intreq_hold", 32'(int_req), 1);
        acc(32'h7f84, 32'h2, 4'hF, 32'h0, 1'b0, "pend_w1c");
        acc(32'h7f84, 32'h0, 4'h0, 32'h0, 1'b0, "pend_rd3");
        check("irq_intreq_clr", 32'(int_req), 0);
        // masked-off line sets PEND but not int_req
        @(negedge clk); dev_irq = 4'h1;
        @(negedge clk); dev_irq = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("irq_masked", 32'(int_req), 0);
        acc(32'h7f84, 32'h0, 4'h0, 32'h1, 1'b0, "pend_rd4");
        acc(32'h7f84, 32'hF, 4'hF, 32'h0, 1'b0, "pend_clr_all");

        // reset during a stalled device read, with int_req pending
        @(negedge clk); dev_irq = 4'h2;
        @(negedge clk); dev_irq = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_intreq_pre", 32'(int_req), 1);
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 32'h7f14; cpu_byteen = 4'h0; dev_ready = '0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("mid_re_active", 32'(dev_re), 32'h2);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_re", 32'(dev_re), 0);
        check("mid_rst_ack", 32'(cpu_ack), 0);
        check("mid_rst_intreq", 32'(int_req), 0);
        check("mid_rst_resp", {31'(cpu_rdata), cpu_err}, 0);
        @(negedge clk); reset = 1'b1; dev_ready = '1;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (cpu_ack) acks++;
        end
        check("mid_no_ack", acks, 0);
        acc(32'h7f80, 32'h0, 4'h0, 32'h0, 1'b0, "mid_mask_rd");
        acc(32'h7f84, 32'h0, 4'h0, 32'h0, 1'b0, "mid_pend_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
